// File: rtl/wb_pkg.sv
// Shared widths, control-field layout and control struct for the write-back stage.
`timescale 1ns/1ps
package wb_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned WBCTL_W        = 2;
    localparam int unsigned CNT_W          = 32;
    localparam int unsigned MEM_TO_REG_BIT = 1;
    localparam int unsigned REG_WRITE_BIT  = 0;

    // WB control as carried in the MEM/WB register: MSB selects load data.
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    // Unpack the raw control field by named bit position.
    function automatic wb_ctrl_t unpack_ctrl(input logic [WBCTL_W-1:0] raw);
        wb_ctrl_t c;
        c.mem_to_reg = raw[MEM_TO_REG_BIT];
        c.reg_write  = raw[REG_WRITE_BIT];
        return c;
    endfunction

endpackage

// File: rtl/wb_mux.sv
// Parameterised 2:1 mux: y = sel ? b : a.
`timescale 1ns/1ps
module wb_mux
    import wb_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Pure select, no state.
    always_comb begin
        y = a;
        if (sel) begin
            y = b;
        end
    end

endmodule

// File: rtl/wb.sv
// Write-back stage: selects register-file write data, passes RegWrite through,
// and keeps a registered copy of the last retired write plus a retire counter.
`timescale 1ns/1ps
module wb
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = wb_pkg::DATA_W
) (
    input  logic [DATA_W-1:0]  In_Address,
    input  logic [DATA_W-1:0]  In_Data,
    input  logic [WBCTL_W-1:0] In_WBControl,
    output logic [DATA_W-1:0]  Out_Data,
    output logic               Out_RegWrite,
    input  logic               Clk,
    input  logic               Reset,
    output logic [DATA_W-1:0]  Out_LastData,
    output logic               Out_LastValid,
    output logic [CNT_W-1:0]   Out_WriteCount
);

    wb_ctrl_t ctrl;

    assign ctrl         = unpack_ctrl(In_WBControl);
    assign Out_RegWrite = ctrl.reg_write;

    // Zero-latency data select; not gated by reset or RegWrite.
    wb_mux #(
        .W (DATA_W)
    ) u_data_mux (
        .sel (ctrl.mem_to_reg),
        .a   (In_Address),
        .b   (In_Data),
        .y   (Out_Data)
    );

    // Retire record: reset wins over a same-edge write; counter wraps freely.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out_LastData   <= '0;
            Out_LastValid  <= 1'b0;
            Out_WriteCount <= '0;
        end else if (ctrl.reg_write) begin
            Out_LastData   <= Out_Data;
            Out_LastValid  <= 1'b1;
            Out_WriteCount <= Out_WriteCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb.sv
// Self-checking bench for the write-back stage against a behavioural model.
`timescale 1ns/1ps
module tb_wb;
    import wb_pkg::*;

    logic              Clk;
    logic              Reset;
    logic [DATA_W-1:0] In_Address;
    logic [DATA_W-1:0] In_Data;
    logic [1:0]        In_WBControl;
    logic [DATA_W-1:0] Out_Data;
    logic              Out_RegWrite;
    logic [DATA_W-1:0] Out_LastData;
    logic              Out_LastValid;
    logic [31:0]       Out_WriteCount;

    int errors = 0;
    int checks = 0;

    // Reference state: what the last retired write and the retire count should be.
    logic [DATA_W-1:0] m_last;
    logic              m_valid;
    logic [31:0]       m_count;

    wb dut (
        .In_Address     (In_Address),
        .In_Data        (In_Data),
        .In_WBControl   (In_WBControl),
        .Out_Data       (Out_Data),
        .Out_RegWrite   (Out_RegWrite),
        .Clk            (Clk),
        .Reset          (Reset),
        .Out_LastData   (Out_LastData),
        .Out_LastValid  (Out_LastValid),
        .Out_WriteCount (Out_WriteCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] ref_data(input logic [1:0] ctl,
                                                   input logic [DATA_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
        return ctl[1] ? data : addr;
    endfunction

    // Advance the model for one rising edge, then let the DUT take the same edge.
    task automatic tick();
        if (Reset) begin
            m_last  = '0;
            m_valid = 1'b0;
            m_count = 32'd0;
        end else if (In_WBControl[0]) begin
            m_last  = ref_data(In_WBControl, In_Address, In_Data);
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_comb_no_edge();
        In_Address = 32'd1; In_Data = 32'd2; In_WBControl = 2'b11; Reset = 1'b1;
        #1;
        checks++;
        if (Out_Data !== 32'd2) begin
            errors++; $display("FAIL comb_no_edge_data: got %h expected %h", Out_Data, 32'd2);
        end
        checks++;
        if (Out_RegWrite !== 1'b1) begin
            errors++; $display("FAIL comb_no_edge_we: got %b expected 1", Out_RegWrite);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (Out_LastData !== '0) begin
            errors++; $display("FAIL reset_last: got %h expected 0", Out_LastData);
        end
        checks++;
        if (Out_LastValid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", Out_LastValid);
        end
        checks++;
        if (Out_WriteCount !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", Out_WriteCount);
        end
    endtask

    task automatic test_select();
        In_Address = 32'h1234; In_Data = 32'hDEAD; In_WBControl = 2'b01;
        #1;
        checks++;
        if (Out_Data !== 32'h1234) begin
            errors++; $display("FAIL sel_addr_data: got %h expected 1234", Out_Data);
        end
        checks++;
        if (Out_RegWrite !== 1'b1) begin
            errors++; $display("FAIL sel_addr_we: got %b expected 1", Out_RegWrite);
        end
        In_WBControl = 2'b10;
        #1;
        checks++;
        if (Out_Data !== 32'hDEAD) begin
            errors++; $display("FAIL sel_mem_data: got %h expected dead", Out_Data);
        end
        checks++;
        if (Out_RegWrite !== 1'b0) begin
            errors++; $display("FAIL sel_mem_we: got %b expected 0", Out_RegWrite);
        end
    endtask

    task automatic test_retire();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        In_WBControl = 2'b11; In_Data = 32'd5; In_Address = 32'h77;
        repeat (3) tick();
        checks++;
        if (Out_LastData !== 32'd5) begin
            errors++; $display("FAIL retire_last: got %h expected 5", Out_LastData);
        end
        checks++;
        if (Out_LastValid !== 1'b1) begin
            errors++; $display("FAIL retire_valid: got %b expected 1", Out_LastValid);
        end
        checks++;
        if (Out_WriteCount !== 32'd3) begin
            errors++; $display("FAIL retire_count: got %0d expected 3", Out_WriteCount);
        end
        In_WBControl = 2'b00; In_Address = 32'd9;
        repeat (2) tick();
        checks++;
        if (Out_Data !== 32'd9) begin
            errors++; $display("FAIL hold_data: got %h expected 9", Out_Data);
        end
        checks++;
        if (Out_LastData !== 32'd5) begin
            errors++; $display("FAIL hold_last: got %h expected 5", Out_LastData);
        end
        checks++;
        if (Out_WriteCount !== 32'd3) begin
            errors++; $display("FAIL hold_count: got %0d expected 3", Out_WriteCount);
        end
    endtask

    task automatic test_reset_priority();
        In_WBControl = 2'b11; In_Data = 32'hCAFE_F00D; In_Address = 32'h1111_2222;
        Reset = 1'b1;
        tick();
        checks++;
        if (Out_LastValid !== 1'b0) begin
            errors++; $display("FAIL rstprio_valid: got %b expected 0", Out_LastValid);
        end
        checks++;
        if (Out_LastData !== '0) begin
            errors++; $display("FAIL rstprio_last: got %h expected 0", Out_LastData);
        end
        checks++;
        if (Out_WriteCount !== 32'd0) begin
            errors++; $display("FAIL rstprio_count: got %0d expected 0", Out_WriteCount);
        end
        checks++;
        if (Out_Data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rstprio_data: got %h expected cafef00d", Out_Data);
        end
        checks++;
        if (Out_RegWrite !== 1'b1) begin
            errors++; $display("FAIL rstprio_we: got %b expected 1", Out_RegWrite);
        end
        Reset = 1'b0;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_d;
        for (int i = 0; i < 400; i++) begin
            Reset        = ($urandom_range(0, 19) == 0);
            In_WBControl = 2'($urandom_range(0, 3));
            In_Address   = $urandom;
            In_Data      = $urandom;
            #1;
            exp_d = ref_data(In_WBControl, In_Address, In_Data);
            checks++;
            if (Out_Data !== exp_d) begin
                errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, Out_Data, exp_d);
            end
            checks++;
            if (Out_RegWrite !== In_WBControl[0]) begin
                errors++; $display("FAIL rand_we[%0d]: got %b expected %b", i, Out_RegWrite, In_WBControl[0]);
            end
            tick();
            checks++;
            if (Out_LastData !== m_last || Out_LastValid !== m_valid || Out_WriteCount !== m_count) begin
                errors++;
                $display("FAIL rand_state[%0d]: got last=%h valid=%b count=%0d expected last=%h valid=%b count=%0d",
                         i, Out_LastData, Out_LastValid, Out_WriteCount, m_last, m_valid, m_count);
            end
        end
        Reset = 1'b0;
    endtask

    task automatic test_wrap();
        Reset = 1'b0;
        In_WBControl = 2'b00;
        force dut.Out_WriteCount = 32'hFFFF_FFFF;
        #1;
        release dut.Out_WriteCount;
        m_count = 32'hFFFF_FFFF;
        In_WBControl = 2'b01; In_Address = 32'hABCD_0123; In_Data = 32'h5555_AAAA;
        tick();
        checks++;
        if (Out_WriteCount !== 32'd0) begin
            errors++; $display("FAIL wrap_count: got %h expected 0", Out_WriteCount);
        end
        checks++;
        if (Out_LastData !== 32'hABCD_0123 || Out_LastValid !== 1'b1) begin
            errors++; $display("FAIL wrap_last: got %h/%b expected abcd0123/1", Out_LastData, Out_LastValid);
        end
        In_WBControl = 2'b11;
        tick();
        checks++;
        if (Out_WriteCount !== 32'd1) begin
            errors++; $display("FAIL wrap_next: got %0d expected 1", Out_WriteCount);
        end
        checks++;
        if (Out_LastData !== 32'h5555_AAAA) begin
            errors++; $display("FAIL wrap_next_last: got %h expected 5555aaaa", Out_LastData);
        end
        In_WBControl = 2'b00;
    endtask

    initial begin
        m_last  = '0;
        m_valid = 1'b0;
        m_count = 32'd0;
        test_comb_no_edge();
        test_reset();
        test_select();
        test_retire();
        test_reset_priority();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb.md
Name: wb

Overview:
- Write-back stage of the 5-stage MIPS-style pipeline. Sits after the MEM/WB pipeline register.
- Selects the register-file write data and forwards the RegWrite enable to the register file.
  - Write data is either the ALU result (the address) or the memory load data.
- Also holds a one-entry registered copy of the last retired write, used by forwarding and debug logic.

Parameters:
- DATA_W, 32, width of the datapath, the ALU result and the memory data.

Ports:
- Clk  input  1  pipeline clock; the registered state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- In_Address  input  DATA_W  ALU result / effective address from MEM/WB.
- In_Data  input  DATA_W  memory read data from MEM/WB.
- In_WBControl  input  2  WB control: [1] MemToReg, [0] RegWrite.
- Out_Data  output  DATA_W  register-file write data.
- Out_RegWrite  output  1  register-file write enable.
- Out_LastData  output  DATA_W  data of the most recent cycle with RegWrite=1.
- Out_LastValid  output  1  Out_LastData holds a valid retired write.
- Out_WriteCount  output  32  number of cycles retired with RegWrite=1 since reset.
- Positional declaration order is fixed: In_Address, In_Data, In_WBControl, Out_Data, Out_RegWrite, Clk, Reset, Out_LastData, Out_LastValid, Out_WriteCount.
  - Existing positional instantiations with six ports must keep working.

Behaviour:
- Out_Data is combinational with zero latency:
  - MemToReg=1 -> In_Data.
  - MemToReg=0 -> In_Address.
- Out_RegWrite is combinational and equals In_WBControl[0].
- Out_Data and Out_RegWrite are valid without any clock edge, and also before or during reset; reset does not gate them.
- Out_Data follows the MemToReg select even when RegWrite=0; consumers qualify it with Out_RegWrite.
- Registered state updates on the rising edge of Clk.
- Reset=1 at a rising edge:
  - Out_LastData <= 0.
  - Out_LastValid <= 0.
  - Out_WriteCount <= 0.
  - Reset has priority over a simultaneous RegWrite=1; that write is not recorded.
- Not in reset, RegWrite=1 at a rising edge:
  - Out_LastData <= the current Out_Data.
  - Out_LastValid <= 1.
  - Out_WriteCount <= Out_WriteCount+1.
- Not in reset, RegWrite=0 at a rising edge: all registered outputs hold their values.
- Out_WriteCount is unsigned and wraps from 0xFFFFFFFF to 0; there is no saturation and no overflow flag.
- Reset asserted mid-operation clears the registered outputs at the next edge. The combinational path is unaffected.
- Power-up values before the first reset are undefined; the bench must apply reset first.

Decomposition:
- Package wb_pkg holds:
  - DATA_W = 32.
  - WBCTL_W = 2.
  - Bit indices MEM_TO_REG_BIT = 1 and REG_WRITE_BIT = 0.
  - Packed typedef wb_ctrl_t {mem_to_reg, reg_write}.
- One sub-module is natural: wb_mux, a parameterised 2:1 DATA_W mux (sel, a, b -> y).
  - wb instantiates it for the Out_Data selection.
  - The retire register and the counter stay inline in wb.

Test Plan:
- In_Address=1, In_Data=2, In_WBControl=2'b11; check at t=1ns with Clk=0 and no edge yet -> Out_Data=2, Out_RegWrite=1.
- In_Address=0x1234, In_Data=0xDEAD, In_WBControl=2'b01 -> Out_Data=0x1234, Out_RegWrite=1. Then 2'b10 -> Out_Data=0xDEAD, Out_RegWrite=0.
- Reset=1 for one edge, then WBControl=2'b11, In_Data=5 for 3 edges -> Out_LastData=5, Out_LastValid=1, Out_WriteCount=3.
- After the previous case, WBControl=2'b00, In_Address=9 for 2 edges -> Out_Data=9, Out_LastData stays 5, Out_WriteCount stays 3.
- Reset=1 together with RegWrite=1 at an edge -> Out_LastValid=0, Out_LastData=0, Out_WriteCount=0, while Out_Data still reflects the inputs.
- Force Out_WriteCount to 0xFFFFFFFF via 2^32-1 writes, or a hierarchical preload; one more RegWrite edge -> Out_WriteCount=0.
